conv_layer_sequencer: RTL and testbench
=======================================

Name: conv_layer_sequencer

Overview:
Sequences one convolution layer pass for the per-featuremap Conv2D3x3 groups.
- Streams the IMG_SIZE x IMG_SIZE input frame, one 96-bit pixel (3 channels x 32-bit float) per cycle, from the input frame memory into the featuremap instances.
- Drives their shared valid_in and counts their valid_out until all (IMG_SIZE-2)^2 output pixels have appeared.
- Signals done, or error on drain timeout.
- Sits between the frame buffer and the layer_N_featuremap_M blocks; one sequencer serves all featuremaps of a layer.

Parameters:
- IMG_SIZE, 416, frame width/height in pixels.
- DATA_IN_WIDTH, 96, pixel word width (3 x 32-bit channels).
- ADDR_WIDTH, 18, frame memory address width; must satisfy 2^ADDR_WIDTH >= IMG_SIZE^2.
- RD_LATENCY, 1, frame memory read latency in cycles (1..4).
- DRAIN_TIMEOUT, 4096, maximum idle cycles in DRAIN with no fm_valid_out before error.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a pass when idle, ignored otherwise.
- stall  in  1  downstream hold; while high, no new read is issued.
- rd_en  out  1  frame memory read enable.
- rd_addr  out  ADDR_WIDTH  frame memory read address, raster order.
- rd_data  in  DATA_IN_WIDTH  frame memory read data, valid RD_LATENCY cycles after rd_en.
- fm_data  out  DATA_IN_WIDTH  pixel to featuremaps (data_in).
- fm_valid_in  out  1  pixel valid to featuremaps (valid_in).
- fm_valid_out  in  1  valid_out from featuremap instance 0; all instances are lockstep.
- busy  out  1  high from the cycle after start until done/error.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on drain timeout.
- out_count  out  ADDR_WIDTH  number of fm_valid_out pulses seen in the current pass.

Behaviour:
- Reset (Rst=0 at an edge):
  - state=IDLE; all outputs 0, including fm_data and out_count.
  - Read-delay line cleared, so no in-flight valid survives.
  - Reset mid-pass aborts with no done/error pulse.
- IDLE:
  - start=1 -> FETCH; rd_addr, out_count, timeout counter cleared.
  - busy rises on the next cycle.
- FETCH:
  - Each cycle with stall=0: rd_en=1 at the current rd_addr, then rd_addr increments.
  - stall=1: rd_en=0, rd_addr held.
  - The read issued at rd_addr = IMG_SIZE^2-1 is the last; the next state is DRAIN.
  - rd_addr never exceeds IMG_SIZE^2-1 (no wrap).
- Data alignment:
  - fm_valid_in = rd_en delayed RD_LATENCY+1 cycles.
  - fm_data = rd_data registered once, so it is aligned with fm_valid_in.
  - fm_data holds its last value when fm_valid_in=0.
- out_count increments on every fm_valid_out=1, in any non-IDLE state.
  - Width rule: saturates at 2^ADDR_WIDTH-1 (never wraps).
- DRAIN:
  - Timeout counter resets on each fm_valid_out and increments otherwise.
  - out_count reaching (IMG_SIZE-2)^2 -> DONE. This includes the cycle in which the final pulse arrives; success takes priority over timeout in the same cycle.
  - Timeout counter reaching DRAIN_TIMEOUT -> ERR.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- ERR: error=1 for one cycle, busy=0 -> IDLE.
- out_count holds its value in IDLE until the next start.
- start while busy: ignored, no restart.
- start in the same cycle as a done pulse: ignored; a new pass needs start while in IDLE.
- stall has no effect on in-flight reads or on counting fm_valid_out; it only gates issue.
- Latency: first rd_en is 1 cycle after start; first fm_valid_in is RD_LATENCY+2 cycles after start, absent stall.

Decomposition:
- Shared package conv_seq_pkg:
  - state enum {IDLE, FETCH, DRAIN, DONE, ERR}.
  - Functions num_pixels(IMG_SIZE) = IMG_SIZE^2 and num_out_pixels(IMG_SIZE) = (IMG_SIZE-2)^2.
  - Default constants for pixel width (96) and channel width (32).
- One sub-module, conv_valid_delay: parameterised N-stage shift register (N=RD_LATENCY+1) with synchronous active-low clear, carrying rd_en to fm_valid_in.

Test Plan:
- Basic pass (IMG_SIZE=4, RD_LATENCY=1; featuremap model emits 4 fm_valid_out):
  - start -> rd_addr 0..15 on 16 consecutive cycles; fm_valid_in high 16 cycles starting 3 cycles after start.
  - done pulses once with out_count=4; busy falls the same cycle.
- Stall (IMG_SIZE=4): stall=1 for 5 cycles after the 6th read -> rd_addr holds at 6; total rd_en pulses stay 16; completion is delayed exactly 5 cycles; done still pulses.
- Timeout (IMG_SIZE=4, DRAIN_TIMEOUT=8): model emits only 3 fm_valid_out -> error pulses 8 cycles after the last pulse; done never asserts; out_count=3.
- Reset mid-FETCH (Rst=0 at rd_addr=7): the next cycle shows rd_en=0, fm_valid_in=0, busy=0, out_count=0; no done/error; a subsequent start restarts at rd_addr=0.
- Ignored start (IMG_SIZE=4): start pulsed during FETCH and during DRAIN -> rd_addr sequence unaffected; exactly one done.
- Latency sweep RD_LATENCY=1..4 with a memory model returning data=address:
  - Each fm_valid_in cycle carries fm_data equal to the address in sequence 0,1,2,...
  - Alignment is checked against the fm_valid_in delay of RD_LATENCY+1 cycles.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg
//   Shared types and helpers for the convolution layer sequencer.
//   - state_e         : sequencer FSM states
//   - num_pixels      : pixels in one IMG_SIZE x IMG_SIZE input frame
//   - num_out_pixels  : valid 3x3 convolution outputs for that frame
//   - PIXEL_WIDTH / CHANNEL_WIDTH : default pixel word (3 x 32-bit float channels)
package conv_seq_pkg;

    localparam int unsigned CHANNEL_WIDTH = 32;
    localparam int unsigned PIXEL_WIDTH   = 3 * CHANNEL_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone,
        StErr
    } state_e;

    function automatic int unsigned num_pixels(input int unsigned img_size);
        return img_size * img_size;
    endfunction

    // A 3x3 kernel without padding loses one pixel on each border.
    function automatic int unsigned num_out_pixels(input int unsigned img_size);
        return (img_size - 2) * (img_size - 2);
    endfunction

endpackage

// File: rtl/conv_valid_delay.sv
// conv_valid_delay
//   N-stage shift register for a single valid bit, synchronous active-low clear.
//   Ports:
//     i_clk   : clock, rising edge
//     i_clr_n : synchronous clear, active low; empties every stage
//     i_d     : bit entering the line
//     o_pre   : i_d delayed N-1 cycles (stage before the output)
//     o_q     : i_d delayed N cycles
module conv_valid_delay #(
    parameter int unsigned N = 2
) (
    input  logic i_clk,
    input  logic i_clr_n,
    input  logic i_d,
    output logic o_pre,
    output logic o_q
);

    logic [N-1:0] r_sr;

    generate
        if (N == 1) begin : g_one
            always_ff @(posedge i_clk) begin
                if (!i_clr_n) begin
                    r_sr <= 1'b0;
                end else begin
                    r_sr <= i_d;
                end
            end
            assign o_pre = i_d;
        end else begin : g_many
            always_ff @(posedge i_clk) begin
                if (!i_clr_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[N-2:0], i_d};
                end
            end
            assign o_pre = r_sr[N-2];
        end
    endgenerate

    assign o_q = r_sr[N-1];

endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
//   Runs one convolution layer pass: streams the input frame from frame memory to all
//   featuremap instances in raster order, then waits for the featuremaps to emit every
//   output pixel, finishing with a done pulse or an error pulse on drain timeout.
//   Ports:
//     i_clk          : clock, rising edge
//     i_rst_n        : synchronous reset, active low; aborts a pass silently
//     i_start        : one-cycle pulse, starts a pass when idle
//     i_stall        : downstream hold, blocks issue of new reads
//     o_rd_en        : frame memory read enable
//     o_rd_addr      : frame memory read address (raster order)
//     i_rd_data      : frame memory data, RD_LATENCY cycles after o_rd_en
//     o_fm_data      : pixel to featuremaps
//     o_fm_valid_in  : pixel valid to featuremaps
//     i_fm_valid_out : output valid from featuremap instance 0
//     o_busy         : pass in progress
//     o_done         : one-cycle pulse, pass completed
//     o_error        : one-cycle pulse, drain timed out
//     o_out_count    : featuremap outputs seen in the current pass (saturating)
module conv_layer_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned IMG_SIZE      = 416,
    parameter int unsigned DATA_IN_WIDTH = PIXEL_WIDTH,
    parameter int unsigned ADDR_WIDTH    = 18,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_stall,
    output logic                     o_rd_en,
    output logic [ADDR_WIDTH-1:0]    o_rd_addr,
    input  logic [DATA_IN_WIDTH-1:0] i_rd_data,
    output logic [DATA_IN_WIDTH-1:0] o_fm_data,
    output logic                     o_fm_valid_in,
    input  logic                     i_fm_valid_out,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    output logic [ADDR_WIDTH-1:0]    o_out_count
);

    localparam int unsigned TmrW = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(num_pixels(IMG_SIZE) - 1);
    localparam logic [ADDR_WIDTH-1:0] OutTarget = ADDR_WIDTH'(num_out_pixels(IMG_SIZE));
    localparam logic [ADDR_WIDTH-1:0] CountMax  = '1;
    localparam logic [TmrW-1:0]       TmrLimit  = TmrW'(DRAIN_TIMEOUT);

    state_e                     r_state;
    logic [ADDR_WIDTH-1:0]      r_rd_addr;
    logic [ADDR_WIDTH-1:0]      r_out_count;
    logic [TmrW-1:0]            r_timer;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_error;
    logic [DATA_IN_WIDTH-1:0]   r_fm_data;

    logic                       w_rd_en;
    logic                       w_data_valid;
    logic                       w_fm_valid_in;
    logic [ADDR_WIDTH-1:0]      w_count_next;
    logic [TmrW-1:0]            w_timer_inc;
    logic                       w_drain_ok;

    // Issue gating is combinational so a stall blocks the read in the same cycle.
    assign w_rd_en = (r_state == StFetch) && !i_stall;

    always_comb begin
        w_count_next = r_out_count;
        if ((r_state != StIdle) && i_fm_valid_out && (r_out_count != CountMax)) begin
            w_count_next = r_out_count + 1'b1;
        end
    end

    // Uses the post-increment count so the final pulse completes the pass immediately.
    assign w_drain_ok  = (w_count_next >= OutTarget);
    assign w_timer_inc = r_timer + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_rd_addr   <= '0;
            r_out_count <= '0;
            r_timer     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_out_count <= w_count_next;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state     <= StFetch;
                        r_rd_addr   <= '0;
                        r_out_count <= '0;
                        r_timer     <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                StFetch: begin
                    if (!i_stall) begin
                        // Address stops at the last pixel rather than wrapping.
                        if (r_rd_addr == LastAddr) begin
                            r_state <= StDrain;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (w_drain_ok) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (i_fm_valid_out) begin
                        r_timer <= '0;
                    end else if (w_timer_inc == TmrLimit) begin
                        r_state <= StErr;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                StDone, StErr: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // RD_LATENCY+1 stages: o_pre marks the cycle rd_data is valid, o_q marks the
    // cycle the registered copy reaches the featuremaps.
    conv_valid_delay #(
        .N(RD_LATENCY + 1)
    ) u_valid_delay (
        .i_clk   (i_clk),
        .i_clr_n (i_rst_n),
        .i_d     (w_rd_en),
        .o_pre   (w_data_valid),
        .o_q     (w_fm_valid_in)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fm_data <= '0;
        end else if (w_data_valid) begin
            r_fm_data <= i_rd_data;
        end
    end

    assign o_rd_en       = w_rd_en;
    assign o_rd_addr     = r_rd_addr;
    assign o_fm_data     = r_fm_data;
    assign o_fm_valid_in = w_fm_valid_in;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign o_out_count   = r_out_count;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: four instances (RD_LATENCY 1..4) share start/stall/reset.
// Each has a frame memory model returning data = address and a featuremap stub that pulses
// fm_valid_out one cycle after receiving pixel (r,c) with r>=2 and c>=2.
module tb_conv_layer_sequencer;

    localparam int unsigned Img   = 4;
    localparam int unsigned Aw    = 18;
    localparam int unsigned Dw    = 96;
    localparam int unsigned To    = 8;
    localparam int          NLat  = 4;
    localparam int          NPix  = Img * Img;
    localparam int          NOut  = (Img - 2) * (Img - 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic drop_last = 1'b0;

    logic [NLat-1:0]         rd_en, fm_valid_in, busy, done, error;
    logic [NLat-1:0]         fvo = '0;
    logic [NLat-1:0][Aw-1:0] rd_addr, out_count;
    logic [NLat-1:0][Dw-1:0] fm_data;
    logic [NLat-1:0][Dw-1:0] rd_data = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NLat; g++) begin : g_dut
        conv_layer_sequencer #(
            .IMG_SIZE      (Img),
            .DATA_IN_WIDTH (Dw),
            .ADDR_WIDTH    (Aw),
            .RD_LATENCY    (g + 1),
            .DRAIN_TIMEOUT (To)
        ) u_dut (
            .i_clk          (clk),
            .i_rst_n        (rst_n),
            .i_start        (start),
            .i_stall        (stall),
            .o_rd_en        (rd_en[g]),
            .o_rd_addr      (rd_addr[g]),
            .i_rd_data      (rd_data[g]),
            .o_fm_data      (fm_data[g]),
            .o_fm_valid_in  (fm_valid_in[g]),
            .i_fm_valid_out (fvo[g]),
            .o_busy         (busy[g]),
            .o_done         (done[g]),
            .o_error        (error[g]),
            .o_out_count    (out_count[g])
        );
    end

    task automatic chk(input string name, input int g, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lat=%0d t=%0t actual=%0h required=%0h", name, g + 1, $time,
                     act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Environment: frame memory (latency g+1, data = address) and featuremap stub.
    logic [Dw-1:0] pipe [NLat][4];
    int            pix [NLat];
    int            emitted [NLat];
    logic [NLat-1:0] fvo_nx;

    initial begin : env
        for (int g = 0; g < NLat; g++) begin
            pix[g] = 0;
            emitted[g] = 0;
            for (int k = 0; k < 4; k++) pipe[g][k] = '1;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < NLat; g++) begin
                for (int k = 3; k > 0; k--) pipe[g][k] = pipe[g][k-1];
                pipe[g][0] = rd_en[g] ? Dw'(rd_addr[g]) : '1;
                fvo_nx[g] = 1'b0;
                if (!rst_n) begin
                    pix[g] = 0;
                    emitted[g] = 0;
                end else if (fm_valid_in[g]) begin
                    if ((pix[g] / Img >= 2) && (pix[g] % Img >= 2)) begin
                        if (!(drop_last && emitted[g] == NOut - 1)) fvo_nx[g] = 1'b1;
                        emitted[g]++;
                    end
                    if (pix[g] == NPix - 1) begin
                        pix[g] = 0;
                        emitted[g] = 0;
                    end else begin
                        pix[g]++;
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int g = 0; g < NLat; g++) begin
                rd_data[g] = pipe[g][g];
                fvo[g] = fvo_nx[g];
            end
        end
    end

    // Behavioural model: phase 0 idle, 1 fetch, 2 drain, 3 done, 4 error.
    int            m_ph [NLat];
    int            m_addr [NLat];
    longint        m_cnt [NLat];
    int            m_idle [NLat];
    logic          m_vh [NLat][8];
    int            m_ah [NLat][8];
    logic          m_fvi [NLat];
    logic [Dw-1:0] m_fmd [NLat];
    bit            m_ok = 0;

    // Event monitor for the hand-computed literal checks.
    int n_done [NLat], n_err [NLat], n_rden [NLat], n_fvi [NLat];
    int done_off [NLat], err_off [NLat], fvi_first [NLat], pix_seq [NLat];

    task automatic clear_mon();
        for (int g = 0; g < NLat; g++) begin
            n_done[g] = 0; n_err[g] = 0; n_rden[g] = 0; n_fvi[g] = 0;
            done_off[g] = -1; err_off[g] = -1; fvi_first[g] = -1; pix_seq[g] = 0;
        end
    endtask

    initial begin : model
        logic en;
        forever begin
            @(negedge clk);
            for (int g = 0; g < NLat; g++) begin
                if (m_ok) begin
                    chk("rd_en", g, rd_en[g], (m_ph[g] == 1) && !stall);
                    chk("rd_addr", g, rd_addr[g], m_addr[g]);
                    chk("busy", g, busy[g], (m_ph[g] == 1) || (m_ph[g] == 2));
                    chk("done", g, done[g], m_ph[g] == 3);
                    chk("error", g, error[g], m_ph[g] == 4);
                    chk("out_count", g, out_count[g], m_cnt[g]);
                    chk("fm_valid_in", g, fm_valid_in[g], m_fvi[g]);
                    chk("fm_data", g, fm_data[g], m_fmd[g]);
                end
                if (done[g]) begin n_done[g]++; done_off[g] = cyc - t0; end
                if (error[g]) begin n_err[g]++; err_off[g] = cyc - t0; end
                if (rd_en[g]) n_rden[g]++;
                if (fm_valid_in[g]) begin
                    if (fvi_first[g] < 0) fvi_first[g] = cyc - t0;
                    n_fvi[g]++;
                    chk("fm_data_seq", g, fm_data[g], pix_seq[g]);
                    pix_seq[g]++;
                end
                en = (m_ph[g] == 1) && !stall;
                if (!rst_n) begin
                    m_ph[g] = 0; m_addr[g] = 0; m_cnt[g] = 0; m_idle[g] = 0;
                    m_fvi[g] = 1'b0; m_fmd[g] = '0;
                    for (int k = 0; k < 8; k++) begin m_vh[g][k] = 1'b0; m_ah[g][k] = 0; end
                end else begin
                    for (int k = 7; k > 0; k--) begin
                        m_vh[g][k] = m_vh[g][k-1];
                        m_ah[g][k] = m_ah[g][k-1];
                    end
                    m_vh[g][0] = en;
                    m_ah[g][0] = m_addr[g];
                    // Pixel reaches the featuremaps RD_LATENCY+1 cycles after its read.
                    m_fvi[g] = m_vh[g][g+1];
                    if (m_fvi[g]) m_fmd[g] = Dw'(m_ah[g][g+1]);
                    if (m_ph[g] != 0 && fvo[g] && m_cnt[g] < (64'd1 << Aw) - 1) m_cnt[g]++;
                    case (m_ph[g])
                        0: if (start) begin
                            m_ph[g] = 1; m_addr[g] = 0; m_cnt[g] = 0; m_idle[g] = 0;
                        end
                        1: if (en) begin
                            if (m_addr[g] == NPix - 1) m_ph[g] = 2;
                            else m_addr[g]++;
                        end
                        2: if (m_cnt[g] >= NOut) m_ph[g] = 3;
                           else if (fvo[g]) m_idle[g] = 0;
                           else begin
                               m_idle[g]++;
                               if (m_idle[g] == To) m_ph[g] = 4;
                           end
                        default: m_ph[g] = 0;
                    endcase
                end
            end
            m_ok = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        t0 = cyc;
        tick(1);
        start = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        clear_mon();
        tick(3);
        chk("reset_busy", 0, busy[0], 0);
        chk("reset_rd_en", 0, rd_en[0], 0);
        chk("reset_out_count", 0, out_count[0], 0);
        chk("reset_fm_data", 0, fm_data[0], 0);
        rst_n = 1'b1;
        tick(2);

        // Basic pass: done lands RD_LATENCY+19 cycles after start with 4 outputs.
        clear_mon();
        pulse_start();
        tick(40);
        for (int g = 0; g < NLat; g++) begin
            chk("basic_done_off", g, done_off[g], g + 20);
            chk("basic_n_done", g, n_done[g], 1);
            chk("basic_n_err", g, n_err[g], 0);
            chk("basic_n_rden", g, n_rden[g], 16);
            chk("basic_n_fvi", g, n_fvi[g], 16);
            chk("basic_fvi_first", g, fvi_first[g], g + 3);
            chk("basic_out_count", g, out_count[g], 4);
        end

        // Stall for 5 cycles after the 6th read: completion slips by exactly 5.
        clear_mon();
        pulse_start();
        tick(6);
        stall = 1'b1;
        tick(3);
        for (int g = 0; g < NLat; g++) begin
            chk("stall_hold_addr", g, rd_addr[g], 6);
            chk("stall_rd_en", g, rd_en[g], 0);
        end
        tick(2);
        stall = 1'b0;
        tick(35);
        for (int g = 0; g < NLat; g++) begin
            chk("stall_done_off", g, done_off[g], g + 25);
            chk("stall_n_done", g, n_done[g], 1);
            chk("stall_n_rden", g, n_rden[g], 16);
        end

        // Timeout: last output dropped; error once 8 idle drain cycles have elapsed.
        drop_last = 1'b1;
        clear_mon();
        pulse_start();
        tick(40);
        for (int g = 0; g < NLat; g++) begin
            chk("timeout_err_off", g, err_off[g], g + 27);
            chk("timeout_n_err", g, n_err[g], 1);
            chk("timeout_n_done", g, n_done[g], 0);
            chk("timeout_out_count", g, out_count[g], 3);
        end
        drop_last = 1'b0;

        // Reset while rd_addr = 7: silent abort, then a clean restart.
        clear_mon();
        pulse_start();
        tick(7);
        for (int g = 0; g < NLat; g++) chk("pre_reset_addr", g, rd_addr[g], 7);
        rst_n = 1'b0;
        tick(1);
        for (int g = 0; g < NLat; g++) begin
            chk("rst_rd_en", g, rd_en[g], 0);
            chk("rst_fvi", g, fm_valid_in[g], 0);
            chk("rst_busy", g, busy[g], 0);
            chk("rst_out_count", g, out_count[g], 0);
        end
        rst_n = 1'b1;
        clear_mon();
        tick(30);
        for (int g = 0; g < NLat; g++) begin
            chk("rst_no_done", g, n_done[g], 0);
            chk("rst_no_err", g, n_err[g], 0);
        end
        clear_mon();
        pulse_start();
        for (int g = 0; g < NLat; g++) begin
            chk("restart_addr", g, rd_addr[g], 0);
            chk("restart_rd_en", g, rd_en[g], 1);
        end
        tick(40);
        for (int g = 0; g < NLat; g++) chk("restart_n_done", g, n_done[g], 1);

        // Starts during FETCH, DRAIN and on the done cycle of lat 1 are all ignored.
        clear_mon();
        pulse_start();
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(12);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(30);
        for (int g = 0; g < NLat; g++) begin
            chk("ign_done_off", g, done_off[g], g + 20);
            chk("ign_n_done", g, n_done[g], 1);
            chk("ign_n_rden", g, n_rden[g], 16);
            chk("ign_busy", g, busy[g], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
